// File: rtl/exec_mc_sequencer.sv
// Sequencer for a fixed-latency pipelined functional unit in execute_stage:
// starts the FU, stalls the front end until the result is due, then presents it for one cycle.
module exec_mc_sequencer #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned WIDTH   = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             req_valid,
    input  logic [3:0]       req_rd,
    input  logic             i_kill,
    input  logic [WIDTH-1:0] fu_result,
    output logic             fu_start,
    output logic             fu_clken,
    output logic             mc_stall,
    output logic             res_valid,
    output logic [3:0]       res_rd,
    output logic [WIDTH-1:0] res_val,
    output logic [31:0]      mc_busy_cycles,
    output logic             mc_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  res_rd_q;
    logic [31:0] busy_q;
    logic        err_q;
    logic        rst_q;
    logic        blank;

    // Outputs stay quiet in the reset cycle and the cycle after it, so a request
    // still held high across a reset cannot start before the pipeline has settled.
    assign blank = i_reset | rst_q;

    always_comb begin
        fu_start  = 1'b0;
        fu_clken  = 1'b0;
        mc_stall  = 1'b0;
        res_valid = 1'b0;
        res_rd    = '0;
        res_val   = '0;
        if (!blank) begin
            res_rd = (LATENCY == 0) ? req_rd : res_rd_q;
            if (!i_kill) begin
                if (LATENCY == 0) begin
                    fu_start  = req_valid;
                    fu_clken  = 1'b1;
                    res_valid = req_valid;
                    res_val   = req_valid ? fu_result : '0;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            fu_start = req_valid;
                            fu_clken = req_valid;
                            mc_stall = req_valid;
                        end
                        S_BUSY: begin
                            fu_clken = 1'b1;
                            mc_stall = 1'b1;
                        end
                        S_DONE: begin
                            res_valid = 1'b1;
                            res_val   = fu_result;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign mc_busy_cycles = blank ? '0 : busy_q;
    assign mc_err         = blank ? 1'b0 : err_q;

    always_ff @(posedge i_clk) begin
        rst_q <= i_reset;
        if (i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            res_rd_q <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (mc_stall && (busy_q != '1)) begin
                busy_q <= busy_q + 32'd1;
            end
            if ((state_q == S_BUSY) && !i_kill && (!req_valid || (req_rd != res_rd_q))) begin
                err_q <= 1'b1;
            end
            if (i_kill) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else if (LATENCY != 0) begin
                case (state_q)
                    S_IDLE: begin
                        if (fu_start) begin
                            res_rd_q <= req_rd;
                            if (LATENCY == 1) begin
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_BUSY;
                                cnt_q   <= CNT_INIT;
                            end
                        end
                    end
                    S_BUSY: begin
                        if (cnt_q == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exec_mc_sequencer.sv
// Bench for exec_mc_sequencer: directed vector table on LATENCY 0/2/3/4 instances plus a
// randomized run of all LATENCY 0..4 instances against an age-based reference model.
module tb_exec_mc_sequencer;

    localparam int ND = 5;

    typedef struct packed {
        logic        start;
        logic        clken;
        logic        stall;
        logic        valid;
        logic [3:0]  rd;
        logic [31:0] val;
        logic [31:0] busy;
        logic        err;
    } out_t;

    typedef struct {
        bit          rst;
        bit          rv;
        bit [3:0]    rd;
        bit          kill;
        bit [31:0]   fres;
        int          dut;
        bit          frc;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rv = 1'b0;
    logic        kill = 1'b0;
    logic [3:0]  rd = '0;
    logic [31:0] fres = '0;

    logic        o_start [ND];
    logic        o_clken [ND];
    logic        o_stall [ND];
    logic        o_valid [ND];
    logic        o_err   [ND];
    logic [3:0]  o_rd    [ND];
    logic [31:0] o_val   [ND];
    logic [31:0] o_busy  [ND];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        exec_mc_sequencer #(.LATENCY(g), .WIDTH(32)) u_dut (
            .i_clk          (clk),
            .i_reset        (rst),
            .req_valid      (rv),
            .req_rd         (rd),
            .i_kill         (kill),
            .fu_result      (fres),
            .fu_start       (o_start[g]),
            .fu_clken       (o_clken[g]),
            .mc_stall       (o_stall[g]),
            .res_valid      (o_valid[g]),
            .res_rd         (o_rd[g]),
            .res_val        (o_val[g]),
            .mc_busy_cycles (o_busy[g]),
            .mc_err         (o_err[g])
        );
    end

    // Reference model: an op is tracked by its age in cycles since the start cycle.
    bit        m_act  [ND];
    int        m_age  [ND];
    bit [3:0]  m_rd   [ND];
    bit [31:0] m_busy [ND];
    bit        m_err  [ND];
    bit        m_prst = 1'b0;
    out_t      m_exp  [ND];

    function automatic out_t model_out(int d);
        out_t e;
        e = '0;
        if (rst || m_prst) return e;
        e.busy = m_busy[d];
        e.err  = m_err[d];
        e.rd   = (d == 0) ? rd : m_rd[d];
        if (kill) return e;
        if (d == 0) begin
            e.start = rv;
            e.clken = 1'b1;
            e.valid = rv;
            e.val   = rv ? fres : 32'd0;
        end else if (!m_act[d]) begin
            e.start = rv;
            e.clken = rv;
            e.stall = rv;
        end else if (m_age[d] < d) begin
            e.stall = 1'b1;
            e.clken = 1'b1;
        end else begin
            e.valid = 1'b1;
            e.val   = fres;
        end
        return e;
    endfunction

    task automatic model_update();
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                m_act[d]  = 1'b0;
                m_age[d]  = 0;
                m_rd[d]   = '0;
                m_busy[d] = '0;
                m_err[d]  = 1'b0;
            end else begin
                if (m_exp[d].stall && m_busy[d] != 32'hFFFF_FFFF) m_busy[d] = m_busy[d] + 1;
                if (m_act[d] && m_age[d] < d && !kill && (!rv || rd != m_rd[d])) m_err[d] = 1'b1;
                if (kill) begin
                    m_act[d] = 1'b0;
                end else if (m_act[d]) begin
                    if (m_age[d] == d) m_act[d] = 1'b0;
                    else m_age[d] = m_age[d] + 1;
                end else if (m_exp[d].start && d > 0) begin
                    m_act[d] = 1'b1;
                    m_age[d] = 1;
                    m_rd[d]  = rd;
                end
            end
        end
        m_prst = rst;
    endtask

    function automatic out_t dut_out(int d);
        out_t a;
        a.start = o_start[d];
        a.clken = o_clken[d];
        a.stall = o_stall[d];
        a.valid = o_valid[d];
        a.rd    = o_rd[d];
        a.val   = o_val[d];
        a.busy  = o_busy[d];
        a.err   = o_err[d];
        return a;
    endfunction

    task automatic check(input string name, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t: got start=%b clken=%b stall=%b valid=%b rd=%0d val=%h busy=%h err=%b, expected start=%b clken=%b stall=%b valid=%b rd=%0d val=%h busy=%h err=%b",
                     name, $time, a.start, a.clken, a.stall, a.valid, a.rd, a.val, a.busy, a.err,
                     e.start, e.clken, e.stall, e.valid, e.rd, e.val, e.busy, e.err);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        if (v.frc) begin
            #1 force g_dut[2].u_dut.busy_q = 32'hFFFF_FFFE;
            #1 release g_dut[2].u_dut.busy_q;
            m_busy[2] = 32'hFFFF_FFFE;
        end
        @(negedge clk);
        rst  = v.rst;
        rv   = v.rv;
        rd   = v.rd;
        kill = v.kill;
        fres = v.fres;
        #1;
        for (int d = 0; d < ND; d++) begin
            m_exp[d] = model_out(d);
            check($sformatf("model_L%0d", d), dut_out(d), m_exp[d]);
        end
        if (v.dut >= 0) check(tag, dut_out(v.dut), v.exp);
        @(posedge clk);
        model_update();
    endtask

    function automatic vec_t mk(bit r, bit v, bit [3:0] a_rd, bit k, bit [31:0] f, int dut, bit frc,
                                bit s, bit c, bit st, bit vl, bit [3:0] erd, bit [31:0] ev,
                                bit [31:0] eb, bit ee);
        vec_t x;
        x.rst = r; x.rv = v; x.rd = a_rd; x.kill = k; x.fres = f; x.dut = dut; x.frc = frc;
        x.exp.start = s; x.exp.clken = c; x.exp.stall = st; x.exp.valid = vl;
        x.exp.rd = erd; x.exp.val = ev; x.exp.busy = eb; x.exp.err = ee;
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        // L=2 single op
        tbl.push_back(mk(1,0,0,0,0,          2,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,          2,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,5,0,0,          2,0, 1,1,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,5,0,0,          2,0, 0,1,1,0,5,0,1,0));
        tbl.push_back(mk(0,1,5,0,32'hDEADBEEF,2,0, 0,0,0,1,5,32'hDEADBEEF,2,0));
        tbl.push_back(mk(0,0,5,0,0,          2,0, 0,0,0,0,5,0,2,0));
        // L=3 back-to-back ops, no restart in the result cycle
        tbl.push_back(mk(1,0,0,0,0,          3,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,          3,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,          3,0, 1,1,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,          3,0, 0,1,1,0,1,0,1,0));
        tbl.push_back(mk(0,1,1,0,0,          3,0, 0,1,1,0,1,0,2,0));
        tbl.push_back(mk(0,1,1,0,32'h11,     3,0, 0,0,0,1,1,32'h11,3,0));
        tbl.push_back(mk(0,1,2,0,0,          3,0, 1,1,1,0,1,0,3,0));
        tbl.push_back(mk(0,1,2,0,0,          3,0, 0,1,1,0,2,0,4,0));
        tbl.push_back(mk(0,1,2,0,0,          3,0, 0,1,1,0,2,0,5,0));
        tbl.push_back(mk(0,1,2,0,32'h22,     3,0, 0,0,0,1,2,32'h22,6,0));
        tbl.push_back(mk(0,0,2,0,0,          3,0, 0,0,0,0,2,0,6,0));
        // L=4 kill mid-op, clean restart, kill in IDLE does not start
        tbl.push_back(mk(1,0,0,0,0,          4,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,          4,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,7,0,0,          4,0, 1,1,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,7,0,0,          4,0, 0,1,1,0,7,0,1,0));
        tbl.push_back(mk(0,1,7,1,0,          4,0, 0,0,0,0,7,0,2,0));
        tbl.push_back(mk(0,1,8,0,0,          4,0, 1,1,1,0,7,0,2,0));
        tbl.push_back(mk(0,1,8,0,0,          4,0, 0,1,1,0,8,0,3,0));
        tbl.push_back(mk(0,1,8,0,0,          4,0, 0,1,1,0,8,0,4,0));
        tbl.push_back(mk(0,1,8,0,0,          4,0, 0,1,1,0,8,0,5,0));
        tbl.push_back(mk(0,1,8,0,32'hCAFE,   4,0, 0,0,0,1,8,32'hCAFE,6,0));
        tbl.push_back(mk(0,1,3,1,0,          4,0, 0,0,0,0,8,0,6,0));
        tbl.push_back(mk(0,0,3,0,0,          4,0, 0,0,0,0,8,0,6,0));
        // L=0 pass-through
        tbl.push_back(mk(1,1,9,0,7,          0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,9,0,7,          0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,9,0,7,          0,0, 1,1,0,1,9,7,0,0));
        tbl.push_back(mk(0,0,9,0,7,          0,0, 0,1,0,0,9,0,0,0));
        tbl.push_back(mk(0,1,9,1,7,          0,0, 0,0,0,0,9,0,0,0));
        // L=2 rd change in BUSY sets sticky error; reset in BUSY clears everything
        tbl.push_back(mk(1,0,0,0,0,          2,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,          2,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,          2,0, 1,1,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,4,0,0,          2,0, 0,1,1,0,3,0,1,0));
        tbl.push_back(mk(0,1,4,0,32'h55,     2,0, 0,0,0,1,3,32'h55,2,1));
        tbl.push_back(mk(0,0,4,0,0,          2,0, 0,0,0,0,3,0,2,1));
        tbl.push_back(mk(0,1,4,0,0,          2,0, 1,1,1,0,3,0,2,1));
        tbl.push_back(mk(1,1,4,0,0,          2,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,4,0,0,          2,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,4,0,0,          2,0, 0,0,0,0,0,0,0,0));
        // L=2 busy counter saturation from 0xFFFF_FFFE
        tbl.push_back(mk(0,1,6,0,0,          2,1, 1,1,1,0,0,0,32'hFFFF_FFFE,0));
        tbl.push_back(mk(0,1,6,0,0,          2,0, 0,1,1,0,6,0,32'hFFFF_FFFF,0));
        tbl.push_back(mk(0,1,6,0,32'h1,      2,0, 0,0,0,1,6,32'h1,32'hFFFF_FFFF,0));
        tbl.push_back(mk(0,1,6,0,0,          2,0, 1,1,1,0,6,0,32'hFFFF_FFFF,0));
        tbl.push_back(mk(0,1,6,0,0,          2,0, 0,1,1,0,6,0,32'hFFFF_FFFF,0));
        tbl.push_back(mk(0,1,6,0,32'h2,      2,0, 0,0,0,1,6,32'h2,32'hFFFF_FFFF,0));
        tbl.push_back(mk(0,0,6,0,0,          2,0, 0,0,0,0,6,0,32'hFFFF_FFFF,0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d_L%0d", i, tbl[i].dut));
        end

        begin
            vec_t rv_vec;
            rv_vec = mk(1,0,0,0,0, -1,0, 0,0,0,0,0,0,0,0);
            step(rv_vec, "rand_reset");
            for (int i = 0; i < 3000; i++) begin
                rv_vec.rst  = ($urandom_range(0, 99) == 0);
                rv_vec.kill = ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 3) == 0) rv_vec.rv = ~rv_vec.rv;
                if ($urandom_range(0, 7) == 0) rv_vec.rd = 4'($urandom);
                rv_vec.fres = $urandom;
                step(rv_vec, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
